ex_operand_stage: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded instruction fields from decode and resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Routes register, immediate or shift-amount values onto the ALU first/second operator, opcode and signed-operation inputs.
- Retains forwarded values across stalls, so a result that retires while EX is held is not lost.

---
 rtl/ex_operand_stage_pkg.sv | 29 ++
 rtl/ex_operand_stage_if.sv | 25 ++
 rtl/ex_operand_stage_fwd_select.sv | 35 +++
 rtl/ex_operand_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared ALU opcodes, operand-source encodings and widths
package ex_operand_stage_pkg;

    localparam int NB_REG_ADDR_DEF = 5;
    localparam int NB_SHAMT        = 5;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_SRAV = 4'b0001;
    localparam logic [3:0] ALU_SRLV = 4'b0110;
    localparam logic [3:0] ALU_SLLV = 4'b1010;
    localparam logic [3:0] ALU_ADD  = 4'b1100;
    localparam logic [3:0] ALU_SUB  = 4'b1011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b1101;
    localparam logic [3:0] ALU_XOR  = 4'b1110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        SRC_REG    = 2'b00,
        SRC_IMM    = 2'b01,
        SRC_SHAMT  = 2'b10,
        SRC_SHIFTV = 2'b11
    } src_sel_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ALU-facing bundle driven by the operand stage
interface ex_operand_stage_if #(
    parameter int NB_DATA       = 32,
    parameter int NB_ALU_OPCODE = 4,
    parameter int NB_REG_ADDR   = 5
);
    logic [NB_DATA-1:0]       o_first_operator;
    logic [NB_DATA-1:0]       o_second_operator;
    logic [NB_DATA-1:0]       o_store_data;
    logic [NB_ALU_OPCODE-1:0] o_alu_opcode;
    logic                     o_signed_operation;
    logic [NB_REG_ADDR-1:0]   o_wr_addr;
    logic                     o_reg_write;
    logic                     o_valid;

    modport master (
        output o_first_operator, o_second_operator, o_store_data, o_alu_opcode,
               o_signed_operation, o_wr_addr, o_reg_write, o_valid
    );

    modport slave (
        input  o_first_operator, o_second_operator, o_store_data, o_alu_opcode,
               o_signed_operation, o_wr_addr, o_reg_write, o_valid
    );
endinterface

// File: rtl/ex_operand_stage_fwd_select.sv
// rtl/ex_operand_stage_fwd_select.sv - EX/MEM > MEM/WB > register priority forward mux, r0 never forwarded
module ex_operand_stage_fwd_select #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5
) (
    input  logic [NB_REG_ADDR-1:0] i_src_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    input  logic                   i_exmem_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_exmem_wr_addr,
    input  logic [NB_DATA-1:0]     i_exmem_result,
    input  logic                   i_memwb_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_memwb_wr_addr,
    input  logic [NB_DATA-1:0]     i_memwb_data,
    output logic [NB_DATA-1:0]     o_data,
    output logic                   o_hit
);
    logic src_nonzero;
    logic exmem_hit;
    logic memwb_hit;

    assign src_nonzero = (i_src_addr != '0);
    assign exmem_hit   = i_exmem_reg_write && (i_exmem_wr_addr == i_src_addr) && src_nonzero;
    assign memwb_hit   = i_memwb_reg_write && (i_memwb_wr_addr == i_src_addr) && src_nonzero;

    always_comb begin
        o_data = i_reg_data;
        if (exmem_hit) begin
            o_data = i_exmem_result;
        end else if (memwb_hit) begin
            o_data = i_memwb_data;
        end
    end

    assign o_hit = exmem_hit | memwb_hit;
endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand stage with forwarding and sticky stall capture; EX_OPERAND_STAGE_PERF_EN adds perf counters
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int NB_DATA       = 32,
    parameter int NB_ALU_OPCODE = 4,
    parameter int NB_REG_ADDR   = NB_REG_ADDR_DEF,
    parameter int NB_IMM        = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [NB_DATA-1:0]       i_rs_data,
    input  logic [NB_DATA-1:0]       i_rt_data,
    input  logic [NB_REG_ADDR-1:0]   i_rs_addr,
    input  logic [NB_REG_ADDR-1:0]   i_rt_addr,
    input  logic [NB_REG_ADDR-1:0]   i_wr_addr,
    input  logic [NB_SHAMT-1:0]      i_shamt,
    input  logic [NB_IMM-1:0]        i_imm,
    input  logic                     i_imm_sign_ext,
    input  logic [1:0]               i_src_sel,
    input  logic [NB_ALU_OPCODE-1:0] i_alu_opcode,
    input  logic                     i_signed_operation,
    input  logic                     i_reg_write,
    input  logic                     i_exmem_reg_write,
    input  logic [NB_REG_ADDR-1:0]   i_exmem_wr_addr,
    input  logic [NB_DATA-1:0]       i_exmem_result,
    input  logic                     i_memwb_reg_write,
    input  logic [NB_REG_ADDR-1:0]   i_memwb_wr_addr,
    input  logic [NB_DATA-1:0]       i_memwb_data,
    ex_operand_stage_if.master       alu_if
`ifdef EX_OPERAND_STAGE_PERF_EN
    ,
    output logic [31:0]              o_stall_cycles,
    output logic [31:0]              o_fwd_events
`endif
);
    logic                     valid_q,        valid_d;
    logic [NB_DATA-1:0]       rs_q,           rs_d;
    logic [NB_DATA-1:0]       rt_q,           rt_d;
    logic [NB_REG_ADDR-1:0]   rs_addr_q,      rs_addr_d;
    logic [NB_REG_ADDR-1:0]   rt_addr_q,      rt_addr_d;
    logic [NB_REG_ADDR-1:0]   wr_addr_q,      wr_addr_d;
    logic [NB_SHAMT-1:0]      shamt_q,        shamt_d;
    logic [NB_IMM-1:0]        imm_q,          imm_d;
    logic                     imm_sign_ext_q, imm_sign_ext_d;
    src_sel_e                 src_sel_q,      src_sel_d;
    logic [NB_ALU_OPCODE-1:0] alu_opcode_q,   alu_opcode_d;
    logic                     signed_q,       signed_d;
    logic                     reg_write_q,    reg_write_d;

    logic [NB_DATA-1:0] fwd_rs;
    logic [NB_DATA-1:0] fwd_rt;
    logic               rs_hit;
    logic               rt_hit;
    logic [NB_DATA-1:0] imm_ext;
    logic [NB_DATA-1:0] first_op;
    logic [NB_DATA-1:0] second_op;

    ex_operand_stage_fwd_select #(.NB_DATA(NB_DATA), .NB_REG_ADDR(NB_REG_ADDR)) u_fwd_rs (
        .i_src_addr        (rs_addr_q),
        .i_reg_data        (rs_q),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_exmem_wr_addr   (i_exmem_wr_addr),
        .i_exmem_result    (i_exmem_result),
        .i_memwb_reg_write (i_memwb_reg_write),
        .i_memwb_wr_addr   (i_memwb_wr_addr),
        .i_memwb_data      (i_memwb_data),
        .o_data            (fwd_rs),
        .o_hit             (rs_hit)
    );

    ex_operand_stage_fwd_select #(.NB_DATA(NB_DATA), .NB_REG_ADDR(NB_REG_ADDR)) u_fwd_rt (
        .i_src_addr        (rt_addr_q),
        .i_reg_data        (rt_q),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_exmem_wr_addr   (i_exmem_wr_addr),
        .i_exmem_result    (i_exmem_result),
        .i_memwb_reg_write (i_memwb_reg_write),
        .i_memwb_wr_addr   (i_memwb_wr_addr),
        .i_memwb_data      (i_memwb_data),
        .o_data            (fwd_rt),
        .o_hit             (rt_hit)
    );

    // Stall reloads rs/rt with their forwarded values so a result retiring mid-stall survives.
    always_comb begin
        valid_d        = valid_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        rs_addr_d      = rs_addr_q;
        rt_addr_d      = rt_addr_q;
        wr_addr_d      = wr_addr_q;
        shamt_d        = shamt_q;
        imm_d          = imm_q;
        imm_sign_ext_d = imm_sign_ext_q;
        src_sel_d      = src_sel_q;
        alu_opcode_d   = alu_opcode_q;
        signed_d       = signed_q;
        reg_write_d    = reg_write_q;
        if (i_flush) begin
            valid_d        = 1'b0;
            rs_d           = '0;
            rt_d           = '0;
            rs_addr_d      = '0;
            rt_addr_d      = '0;
            wr_addr_d      = '0;
            shamt_d        = '0;
            imm_d          = '0;
            imm_sign_ext_d = 1'b0;
            src_sel_d      = SRC_REG;
            alu_opcode_d   = '0;
            signed_d       = 1'b0;
            reg_write_d    = 1'b0;
        end else if (i_stall) begin
            rs_d = fwd_rs;
            rt_d = fwd_rt;
        end else begin
            valid_d        = i_valid;
            rs_d           = i_rs_data;
            rt_d           = i_rt_data;
            rs_addr_d      = i_rs_addr;
            rt_addr_d      = i_rt_addr;
            wr_addr_d      = i_wr_addr;
            shamt_d        = i_shamt;
            imm_d          = i_imm;
            imm_sign_ext_d = i_imm_sign_ext;
            src_sel_d      = src_sel_e'(i_src_sel);
            alu_opcode_d   = i_alu_opcode;
            signed_d       = i_signed_operation;
            reg_write_d    = i_reg_write;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q        <= 1'b0;
            rs_q           <= '0;
            rt_q           <= '0;
            rs_addr_q      <= '0;
            rt_addr_q      <= '0;
            wr_addr_q      <= '0;
            shamt_q        <= '0;
            imm_q          <= '0;
            imm_sign_ext_q <= 1'b0;
            src_sel_q      <= SRC_REG;
            alu_opcode_q   <= '0;
            signed_q       <= 1'b0;
            reg_write_q    <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            rs_addr_q      <= rs_addr_d;
            rt_addr_q      <= rt_addr_d;
            wr_addr_q      <= wr_addr_d;
            shamt_q        <= shamt_d;
            imm_q          <= imm_d;
            imm_sign_ext_q <= imm_sign_ext_d;
            src_sel_q      <= src_sel_d;
            alu_opcode_q   <= alu_opcode_d;
            signed_q       <= signed_d;
            reg_write_q    <= reg_write_d;
        end
    end

    assign imm_ext = {{(NB_DATA-NB_IMM){imm_sign_ext_q & imm_q[NB_IMM-1]}}, imm_q};

    always_comb begin
        first_op  = fwd_rs;
        second_op = fwd_rt;
        case (src_sel_q)
            SRC_REG: begin
                first_op  = fwd_rs;
                second_op = fwd_rt;
            end
            SRC_IMM: begin
                first_op  = fwd_rs;
                second_op = imm_ext;
            end
            SRC_SHAMT: begin
                first_op  = fwd_rt;
                second_op = {{(NB_DATA-NB_SHAMT){1'b0}}, shamt_q};
            end
            default: begin
                first_op  = fwd_rt;
                second_op = {{(NB_DATA-NB_SHAMT){1'b0}}, fwd_rs[NB_SHAMT-1:0]};
            end
        endcase
    end

    // A bubble presents SLL 0,0 so the ALU result is 0.
    assign alu_if.o_first_operator   = valid_q ? first_op  : '0;
    assign alu_if.o_second_operator  = valid_q ? second_op : '0;
    assign alu_if.o_store_data       = valid_q ? fwd_rt    : '0;
    assign alu_if.o_alu_opcode       = valid_q ? alu_opcode_q : NB_ALU_OPCODE'(ALU_SLL);
    assign alu_if.o_signed_operation = valid_q & signed_q;
    assign alu_if.o_reg_write        = valid_q & reg_write_q;
    assign alu_if.o_wr_addr          = wr_addr_q;
    assign alu_if.o_valid            = valid_q;

`ifdef EX_OPERAND_STAGE_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] fwd_events_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cycles_q <= '0;
            fwd_events_q   <= '0;
        end else begin
            if (i_stall && !i_flush && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (valid_q && (rs_hit || rt_hit) && (fwd_events_q != '1)) begin
                fwd_events_q <= fwd_events_q + 32'd1;
            end
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_fwd_events   = fwd_events_q;
`else
    logic unused_fwd_hits;
    assign unused_fwd_hits = rs_hit | rt_hit;
`endif
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage (honours EX_OPERAND_STAGE_PERF_EN)
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, valid;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  rs_addr, rt_addr, wr_addr, shamt;
    logic [15:0] imm;
    logic        sx;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic        sg, rw;
    logic        ex_rw, wb_rw;
    logic [4:0]  ex_addr, wb_addr;
    logic [31:0] ex_res, wb_data;
`ifdef EX_OPERAND_STAGE_PERF_EN
    logic [31:0] stall_cycles, fwd_events;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        v;
        logic [4:0]  rsa, rta, wr, sh;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
        logic        sx;
        logic [1:0]  sel;
        logic [3:0]  op;
        logic        sg, rw;
    } instr_t;

    instr_t      m;
    int unsigned m_stalls, m_fwds;

    ex_operand_stage_if #(.NB_DATA(32), .NB_ALU_OPCODE(4), .NB_REG_ADDR(5)) alu_if ();

    ex_operand_stage dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_stall            (stall),
        .i_flush            (flush),
        .i_valid            (valid),
        .i_rs_data          (rs_data),
        .i_rt_data          (rt_data),
        .i_rs_addr          (rs_addr),
        .i_rt_addr          (rt_addr),
        .i_wr_addr          (wr_addr),
        .i_shamt            (shamt),
        .i_imm              (imm),
        .i_imm_sign_ext     (sx),
        .i_src_sel          (sel),
        .i_alu_opcode       (op),
        .i_signed_operation (sg),
        .i_reg_write        (rw),
        .i_exmem_reg_write  (ex_rw),
        .i_exmem_wr_addr    (ex_addr),
        .i_exmem_result     (ex_res),
        .i_memwb_reg_write  (wb_rw),
        .i_memwb_wr_addr    (wb_addr),
        .i_memwb_data       (wb_data),
        .alu_if             (alu_if)
`ifdef EX_OPERAND_STAGE_PERF_EN
        ,
        .o_stall_cycles     (stall_cycles),
        .o_fwd_events       (fwd_events)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic hit(input logic [4:0] a);
        return (a != 0) && ((ex_rw && ex_addr == a) || (wb_rw && wb_addr == a));
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (a != 0 && ex_rw && ex_addr == a) return ex_res;
        if (a != 0 && wb_rw && wb_addr == a) return wb_data;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] frs, frt, e1, e2;
        frs = fwd(m.rsa, m.rsd);
        frt = fwd(m.rta, m.rtd);
        case (m.sel)
            2'd0:    begin e1 = frs; e2 = frt; end
            2'd1:    begin e1 = frs; e2 = m.sx ? 32'(signed'(m.imm)) : 32'(m.imm); end
            2'd2:    begin e1 = frt; e2 = 32'(m.sh); end
            default: begin e1 = frt; e2 = frs % 32; end
        endcase
        chk("first",  alu_if.o_first_operator,   m.v ? e1 : 32'd0);
        chk("second", alu_if.o_second_operator,  m.v ? e2 : 32'd0);
        chk("store",  alu_if.o_store_data,       m.v ? frt : 32'd0);
        chk("opcode", 32'(alu_if.o_alu_opcode),  m.v ? 32'(m.op) : 32'd0);
        chk("signed", 32'(alu_if.o_signed_operation), 32'(m.v & m.sg));
        chk("reg_wr", 32'(alu_if.o_reg_write),   32'(m.v & m.rw));
        chk("wr_addr", 32'(alu_if.o_wr_addr),    32'(m.wr));
        chk("valid",  32'(alu_if.o_valid),       32'(m.v));
`ifdef EX_OPERAND_STAGE_PERF_EN
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("fwd_events",   fwd_events,   m_fwds);
`endif
    endtask

    // Advance one clock edge, moving the reference model by the stage's edge rules.
    task automatic tick();
        instr_t nxt;
        nxt = m;
        if (flush) begin
            nxt = '0;
        end else if (stall) begin
            nxt.rsd = fwd(m.rsa, m.rsd);
            nxt.rtd = fwd(m.rta, m.rtd);
        end else begin
            nxt = '{v: valid, rsa: rs_addr, rta: rt_addr, wr: wr_addr, sh: shamt,
                    rsd: rs_data, rtd: rt_data, imm: imm, sx: sx, sel: sel,
                    op: op, sg: sg, rw: rw};
        end
        if (stall && !flush) m_stalls++;
        if (m.v && (hit(m.rsa) || hit(m.rta))) m_fwds++;
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic load_reg(input logic [4:0] a_rs, input logic [31:0] d_rs,
                            input logic [4:0] a_rt, input logic [31:0] d_rt,
                            input logic [1:0] s, input logic [3:0] o);
        valid = 1'b1; rs_addr = a_rs; rs_data = d_rs; rt_addr = a_rt; rt_data = d_rt;
        sel = s; op = o; wr_addr = 5'd9; rw = 1'b1; sg = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0; valid = 0;
        rs_data = 0; rt_data = 0; rs_addr = 0; rt_addr = 0; wr_addr = 0; shamt = 0;
        imm = 0; sx = 0; sel = 0; op = 0; sg = 0; rw = 0;
        ex_rw = 0; wb_rw = 0; ex_addr = 0; wb_addr = 0; ex_res = 0; wb_data = 0;
        m = '0; m_stalls = 0; m_fwds = 0;

        #1 check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // REG mode, no hazards: ADD r3(10), r4(7)
        load_reg(5'd3, 32'd10, 5'd4, 32'd7, 2'b00, 4'b1100);
        tick();
        chk("reg_first", alu_if.o_first_operator, 32'd10);
        chk("reg_second", alu_if.o_second_operator, 32'd7);
        chk("reg_opcode", 32'(alu_if.o_alu_opcode), 32'hC);
        check_all();

        // Double hazard on r3: EX/MEM beats MEM/WB, then r0 targets never forward
        ex_rw = 1; ex_addr = 5'd3; ex_res = 32'h55;
        wb_rw = 1; wb_addr = 5'd3; wb_data = 32'h99;
        #1 chk("dbl_hazard", alu_if.o_first_operator, 32'h55);
        check_all();
        ex_addr = 5'd0; wb_addr = 5'd0;
        #1 chk("r0_guard", alu_if.o_first_operator, 32'd10);
        check_all();
        ex_rw = 0; wb_rw = 0;

        // Asynchronous reset while the stage holds a live instruction
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m = '0; m_stalls = 0; m_fwds = 0;
        chk("async_rst_valid", 32'(alu_if.o_valid), 32'd0);
        check_all();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stall across a MEM/WB retire of r4
        load_reg(5'd3, 32'd10, 5'd4, 32'd7, 2'b00, 4'b1100);
        tick();
        wb_rw = 1; wb_addr = 5'd4; wb_data = 32'h1234;
        stall = 1; valid = 0; rt_data = 32'hDEAD;
        #1 check_all();
        tick();
        tick();
        wb_rw = 0;
        #1 chk("sticky_fwd", alu_if.o_second_operator, 32'h1234);
        chk("stall_keeps_valid", 32'(alu_if.o_valid), 32'd1);
        check_all();
        stall = 0;

        // IMM sign/zero extension, then SHAMT
        load_reg(5'd3, 32'd10, 5'd4, 32'd7, 2'b01, 4'b1100);
        imm = 16'hFFF0; sx = 1;
        tick();
        chk("imm_sext", alu_if.o_second_operator, 32'hFFFF_FFF0);
        check_all();
        sx = 0; op = 4'b1111;
        tick();
        chk("imm_zext", alu_if.o_second_operator, 32'h0000_FFF0);
        check_all();
        load_reg(5'd3, 32'd10, 5'd4, 32'h80, 2'b10, 4'b0000);
        shamt = 5'd5;
        tick();
        chk("shamt_first", alu_if.o_first_operator, 32'h80);
        chk("shamt_second", alu_if.o_second_operator, 32'd5);
        check_all();

        // Flush together with stall: flush wins and the stall is not counted
        stall = 1; flush = 1;
        tick();
        chk("flush_valid", 32'(alu_if.o_valid), 32'd0);
        chk("flush_regwr", 32'(alu_if.o_reg_write), 32'd0);
        chk("flush_first", alu_if.o_first_operator, 32'd0);
        check_all();
        stall = 0; flush = 0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            valid   = 1'($urandom);
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            wr_addr = 5'($urandom);
            rs_data = $urandom;
            rt_data = $urandom;
            shamt   = 5'($urandom);
            imm     = 16'($urandom);
            sx      = 1'($urandom);
            sel     = 2'($urandom);
            op      = 4'($urandom);
            sg      = 1'($urandom);
            rw      = 1'($urandom);
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 11) == 0);
            ex_rw   = 1'($urandom);
            ex_addr = 5'($urandom_range(0, 7));
            ex_res  = $urandom;
            wb_rw   = 1'($urandom);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            #1 check_all();
            tick();
        end
        stall = 0; flush = 0;
        #1 check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
